page_request_issuer: RTL and testbench
======================================

// Module: page_request_issuer
// PURPOSE
//  Consumes the start address from the control register block and walks a host buffer page by page.
//  Issues one page-sized read descriptor per page to the host read queue, tracks completions and
//  bounds the number of in-flight pages. Measures elapsed cycles from start to the last completion;
//  feeds that count back as the control register block's timer input.
// PARAMETERS
//  VADDR_BITS      48    width of virtual address
//  PAGE_BYTES      4096  bytes per descriptor; power of two
//  LEN_BITS        28    width of descriptor length field
//  MAX_OUTSTANDING 16    max issued-but-uncompleted descriptors; power of two, >=2
// PORTS
//  aclk       in   1           clock
//  aresetn    in   1           reset
//  start      in   1           single-cycle pulse; accepted only in IDLE or DONE
//  vaddr      in   VADDR_BITS  buffer base address; sampled on accepted start
//  n_pages    in   32          pages to read; sampled on accepted start
//  req_valid  out  1           descriptor valid
//  req_ready  in   1           descriptor accepted by host queue
//  req_vaddr  out  VADDR_BITS  descriptor address
//  req_len    out  LEN_BITS    descriptor length in bytes, always PAGE_BYTES
//  cpl_valid  in   1           one page completed; single-cycle pulse per page
//  busy       out  1           high in ISSUE or DRAIN
//  done       out  1           high in DONE
//  timer      out  32          elapsed-cycle counter for the controller TIMER register
// BEHAVIOUR
//  Reset is aresetn, synchronous, active-low; clock aclk.
//  Reset values: all outputs 0; state IDLE; all counters 0.
//  States and transitions
//   IDLE  -> ISSUE on start when n_pages != 0. Latches addr_q = vaddr, remaining = n_pages.
//         Clears timer and outstanding.
//   IDLE  -> DONE  on start when n_pages == 0. timer = 0.
//   ISSUE: req_valid = (remaining != 0) && (outstanding < MAX_OUTSTANDING).
//         On req_valid && req_ready:
//           addr_q += PAGE_BYTES; wraps modulo 2^VADDR_BITS with no error.
//           remaining -= 1; outstanding += 1.
//         Go to DRAIN in the cycle after the last page is accepted (remaining == 0).
//   DRAIN: req_valid = 0. Go to DONE when outstanding == 0.
//   DONE : done = 1; timer holds its value. A new start re-arms exactly as from IDLE.
//  Handshake rules
//   req_vaddr and req_len are stable while req_valid && !req_ready.
//   req_valid never drops without a handshake.
//   req_vaddr and req_len are registered outputs; no combinational path from req_ready to req_valid.
//  Completions
//   outstanding -= 1 per cpl_valid.
//   Simultaneous accept and cpl_valid: outstanding unchanged.
//   cpl_valid while outstanding == 0: ignored, outstanding stays 0. Sticky cpl_err bit set
//   internally, visible in simulation only.
//  Timer
//   Increments by 1 every cycle in ISSUE and DRAIN, starting the cycle after start.
//   Saturates at 32'hFFFF_FFFF. Frozen in DONE and IDLE.
//  Other rules
//   start in ISSUE or DRAIN is ignored; latched vaddr and n_pages are unchanged.
//   Reset mid-transfer returns to IDLE immediately. Late cpl_valid pulses after reset fall under
//   the outstanding == 0 rule.
//   outstanding counter width: $clog2(MAX_OUTSTANDING)+1.
// STRUCTURE
//  Shared package (common)
//   PAGE_SIZE constant, reused as the PAGE_BYTES default.
//   vaddr_t typedef for the address ports.
//   req_t struct {vaddr, len} for the descriptor.
//   issuer_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
//  Sub-module
//   credit_counter: up/down counter with a limit, producing outstanding and can_issue.
//  FSM, address generator and timer are kept in this module.
// TESTING
//  1. vaddr=0x1000, n_pages=3, req_ready=1, cpl 5 cycles after each accept
//     -> req_vaddr 0x1000, 0x2000, 0x3000, each with req_len=4096.
//     -> done=1; timer = cycles from start+1 to the last cpl.
//  2. n_pages=40, req_ready=1, no cpl_valid
//     -> exactly 16 accepts, then req_valid=0.
//     -> each cpl_valid releases exactly one further request.
//  3. req_ready random 50%
//     -> req_vaddr/req_len stable while stalled; 8 pages issued in order; no duplicates.
//  4. vaddr=0xFFFF_FFFF_F000, n_pages=2
//     -> second req_vaddr = 0x0 (wrap).
//  5. n_pages=0 -> DONE next cycle; no req_valid; timer=0.
//     start during ISSUE -> ignored.
//  6. aresetn low mid-DRAIN with 4 outstanding -> IDLE, all outputs 0.
//     2 stray cpl_valid pulses -> outstanding stays 0.
//     New start then completes normally.

Source files
------------

// File: rtl/page_request_issuer_pkg.sv
// Shared types and constants for the page request issuer.
// Contents: page size, address/descriptor widths, address and descriptor types, FSM state enum.
package page_request_issuer_pkg;

    localparam int unsigned PAGE_SIZE = 4096;
    localparam int unsigned VADDR_W   = 48;
    localparam int unsigned LEN_W     = 28;
    localparam int unsigned MAX_OUT   = 16;

    typedef logic [VADDR_W-1:0] vaddr_t;

    typedef struct packed {
        vaddr_t           vaddr;
        logic [LEN_W-1:0] len;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } issuer_state_t;

endpackage

// File: rtl/page_request_issuer_credit_counter.sv
// Up/down counter of in-flight descriptors, bounded by LIMIT.
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset
//   clear_i        force the count to zero (new transfer)
//   inc_i          one descriptor accepted
//   dec_i          one completion received
//   count_o        registered outstanding count
//   can_issue_c    next-cycle count is below LIMIT (feeds a registered valid)
module page_request_issuer_credit_counter #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = $clog2(LIMIT) + 1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         can_issue_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         cpl_err_q;
    logic         cpl_err_d;

    // Next count; simultaneous inc/dec cancel, a completion with nothing in flight is dropped.
    always_comb begin
        count_d   = count_q;
        cpl_err_d = cpl_err_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                cpl_err_d = 1'b1;
            end else begin
                count_d = count_q - W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q   <= '0;
            cpl_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            cpl_err_q <= cpl_err_d;
        end
    end

    assign count_o     = count_q;
    assign can_issue_c = (count_d < W'(LIMIT));

endmodule

// File: rtl/page_request_issuer.sv
// Walks a host buffer page by page, issuing one page-sized read descriptor per page,
// bounding in-flight pages and timing the transfer from start to the last completion.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   start, vaddr, n_pages  transfer request (accepted in IDLE or DONE)
//   req_valid/req_ready    descriptor handshake; req_vaddr/req_len payload
//   cpl_valid              one page completed
//   busy, done, timer      status and elapsed-cycle count
module page_request_issuer
    import page_request_issuer_pkg::*;
#(
    parameter int unsigned VADDR_BITS      = VADDR_W,
    parameter int unsigned PAGE_BYTES      = PAGE_SIZE,
    parameter int unsigned LEN_BITS        = LEN_W,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUT
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [VADDR_BITS-1:0] vaddr,
    input  logic [31:0]           n_pages,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [VADDR_BITS-1:0] req_vaddr,
    output logic [LEN_BITS-1:0]   req_len,
    input  logic                  cpl_valid,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           timer
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    issuer_state_t         state_q, state_d;
    logic [VADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [31:0]           timer_q, timer_d;
    logic                  req_valid_q, req_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [OUT_W-1:0]      outstanding;
    logic                  can_issue_c;
    logic                  start_ok;
    logic                  req_fire;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign req_fire = req_valid_q && req_ready;

    page_request_issuer_credit_counter #(
        .LIMIT (MAX_OUTSTANDING),
        .W     (OUT_W)
    ) u_credit (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .clear_i     (start_ok),
        .inc_i       (req_fire),
        .dec_i       (cpl_valid),
        .count_o     (outstanding),
        .can_issue_c (can_issue_c)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (n_pages != 32'd0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (remaining_q == 32'd0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; outputs are registered from these, so
    // req_valid looks ahead using next-cycle remaining pages and credit.
    always_comb begin
        addr_d      = addr_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        if (start_ok) begin
            addr_d      = vaddr;
            len_d       = LEN_BITS'(PAGE_BYTES);
            remaining_d = n_pages;
            timer_d     = 32'd0;
        end else begin
            if (req_fire) begin
                addr_d      = addr_q + VADDR_BITS'(PAGE_BYTES);
                remaining_d = remaining_q - 32'd1;
            end
            if (((state_q == ISSUE) || (state_q == DRAIN)) && (timer_q != '1)) begin
                timer_d = timer_q + 32'd1;
            end
        end
        req_valid_d = (state_d == ISSUE) && (remaining_d != 32'd0) && can_issue_c;
        busy_d      = (state_d == ISSUE) || (state_d == DRAIN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_vaddr = addr_q;
    assign req_len   = len_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timer     = timer_q;

endmodule

// File: tb/tb_page_request_issuer.sv
// Directed, table-driven bench for page_request_issuer.
module tb_page_request_issuer;
    import page_request_issuer_pkg::*;

    localparam int unsigned PB = 4096;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    vaddr_t      vaddr;
    logic [31:0] n_pages;
    logic        req_valid;
    logic        req_ready;
    vaddr_t      req_vaddr;
    logic [27:0] req_len;
    logic        cpl_valid;
    logic        busy;
    logic        done;
    logic [31:0] timer;

    int checks = 0;
    int errors = 0;

    page_request_issuer dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .vaddr     (vaddr),
        .n_pages   (n_pages),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vaddr (req_vaddr),
        .req_len   (req_len),
        .cpl_valid (cpl_valid),
        .busy      (busy),
        .done      (done),
        .timer     (timer)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn   = 1'b0;
        start     = 1'b0;
        req_ready = 1'b0;
        cpl_valid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // One transfer with req_ready high (or random) and each completion `dly` cycles
    // after its accept. Loop index k = number of clock edges since the start edge.
    task automatic run_xfer(input vaddr_t base, input int n, input int dly, input bit rnd,
                            input int exp_timer, input vaddr_t exp_last);
        bit     sched [0:511];
        int     acc = 0;
        int     k = 0;
        bit     got_done = 0;
        bit     prev_stall = 0;
        vaddr_t prev_addr = '0;
        vaddr_t last_addr = '0;
        vaddr_t exp_a;
        for (int i = 0; i < 512; i++) sched[i] = 1'b0;
        @(negedge aclk);
        start = 1'b1; vaddr = base; n_pages = 32'(n); req_ready = 1'b0; cpl_valid = 1'b0;
        @(negedge aclk);
        start = 1'b0; vaddr = '0; n_pages = 32'd0;
        while (k < 400 && !got_done) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(req_valid), 64'(1));
                    chk("stall_addr", 64'(req_vaddr), 64'(prev_addr));
                    chk("stall_len", 64'(req_len), 64'(PB));
                end
                req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                cpl_valid = sched[k];
                if (req_valid && req_ready) begin
                    exp_a = base + vaddr_t'(acc * int'(PB));
                    chk("req_addr", 64'(req_vaddr), 64'(exp_a));
                    chk("req_len", 64'(req_len), 64'(PB));
                    last_addr = req_vaddr;
                    acc++;
                    if (k + dly < 512) sched[k + dly] = 1'b1;
                end
                prev_stall = req_valid && !req_ready;
                prev_addr  = req_vaddr;
                @(negedge aclk);
                k++;
            end
        end
        req_ready = 1'b0;
        cpl_valid = 1'b0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout actual=no_done required=done base=%0h", base);
        end else begin
            chk("timer_measured", 64'(timer), 64'(k));
            if (exp_timer >= 0) chk("timer_table", 64'(timer), 64'(exp_timer));
            chk("accept_count", 64'(acc), 64'(n));
            chk("last_addr", 64'(last_addr), 64'(exp_last));
            chk("done_busy", 64'(busy), 64'(0));
            chk("done_valid", 64'(req_valid), 64'(0));
        end
    endtask

    typedef struct {
        vaddr_t base;
        int     n;
        int     dly;
        bit     rnd;
        int     exp_timer;   // n + dly + 1 when ready is always high; -1 = not fixed
        vaddr_t exp_last;
    } row_t;

    row_t rows [5];

    initial begin
        int     acc;
        vaddr_t base2;

        rows[0] = '{48'h0000_0000_1000, 3, 5, 1'b0, 9, 48'h0000_0000_3000};
        rows[1] = '{48'h0000_0000_8000, 1, 1, 1'b0, 3, 48'h0000_0000_8000};
        rows[2] = '{48'hFFFF_FFFF_F000, 2, 2, 1'b0, 5, 48'h0000_0000_0000};
        rows[3] = '{48'h0000_1234_5000, 5, 3, 1'b0, 9, 48'h0000_1234_9000};
        rows[4] = '{48'h0000_00AB_C000, 8, 4, 1'b1, -1, 48'h0000_00AC_3000};

        aresetn = 1'b0; start = 1'b0; vaddr = '0; n_pages = 32'd0;
        req_ready = 1'b0; cpl_valid = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_valid", 64'(req_valid), 64'(0));
        chk("rst_vaddr", 64'(req_vaddr), 64'(0));
        chk("rst_len", 64'(req_len), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_timer", 64'(timer), 64'(0));
        aresetn = 1'b1;

        for (int r = 0; r < 5; r++) begin
            run_xfer(rows[r].base, rows[r].n, rows[r].dly, rows[r].rnd,
                     rows[r].exp_timer, rows[r].exp_last);
        end

        // Zero-page start from DONE: straight to DONE, timer cleared.
        @(negedge aclk);
        start = 1'b1; vaddr = 48'h5000; n_pages = 32'd0;
        @(negedge aclk);
        start = 1'b0;
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_valid", 64'(req_valid), 64'(0));
        chk("zero_timer", 64'(timer), 64'(0));
        chk("zero_busy", 64'(busy), 64'(0));
        @(negedge aclk);
        chk("zero_valid2", 64'(req_valid), 64'(0));

        // Credit limit: 40 pages, no completions -> 16 accepts then stall.
        base2 = 48'h0000_0010_0000;
        @(negedge aclk);
        start = 1'b1; vaddr = base2; n_pages = 32'd40; req_ready = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        acc = 0;
        repeat (30) begin
            if (req_valid && req_ready) acc++;
            @(negedge aclk);
        end
        chk("limit_accepts", 64'(acc), 64'(16));
        chk("limit_valid", 64'(req_valid), 64'(0));
        chk("limit_busy", 64'(busy), 64'(1));
        // start during ISSUE must be ignored
        start = 1'b1; vaddr = 48'h0000_9990_0000; n_pages = 32'd1;
        @(negedge aclk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cpl_valid = 1'b1;
            @(negedge aclk);
            cpl_valid = 1'b0;
            acc = 0;
            repeat (6) begin
                if (req_valid && req_ready) begin
                    acc++;
                    chk("credit_addr", 64'(req_vaddr), 64'(base2 + vaddr_t'((16 + j) * int'(PB))));
                end
                @(negedge aclk);
            end
            chk("credit_release", 64'(acc), 64'(1));
        end
        chk("ignored_start_busy", 64'(busy), 64'(1));
        do_reset();

        // Reset in DRAIN with 4 outstanding, then stray completions.
        @(negedge aclk);
        start = 1'b1; vaddr = 48'h2000; n_pages = 32'd4; req_ready = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (8) @(negedge aclk);
        chk("drain_busy", 64'(busy), 64'(1));
        chk("drain_valid", 64'(req_valid), 64'(0));
        chk("drain_outstanding", 64'(dut.u_credit.count_q), 64'(4));
        aresetn = 1'b0; req_ready = 1'b0;
        @(negedge aclk);
        chk("mid_rst_valid", 64'(req_valid), 64'(0));
        chk("mid_rst_vaddr", 64'(req_vaddr), 64'(0));
        chk("mid_rst_len", 64'(req_len), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_timer", 64'(timer), 64'(0));
        aresetn = 1'b1;
        repeat (2) begin
            @(negedge aclk); cpl_valid = 1'b1;
            @(negedge aclk); cpl_valid = 1'b0;
        end
        @(negedge aclk);
        chk("stray_outstanding", 64'(dut.u_credit.count_q), 64'(0));
        chk("stray_done", 64'(done), 64'(0));
        run_xfer(48'h4000, 2, 2, 1'b0, 5, 48'h5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
